// File: rtl/event_rr_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : event_rr_dispatch
// Purpose  : Round-robin dispatcher that pops events from FWFT FIFOs onto one
//            registered valid/ready stream, tagging each with its source index.
// Revision : 1.0 - initial release
// ============================================================================
module event_rr_dispatch #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SRC_W  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN-1:0]       in_empty,
   input  logic [NUM_IN*WIDTH-1:0] in_dout,
   output logic [NUM_IN-1:0]       in_rd_en,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SRC_W-1:0]        out_src,
   output logic [15:0]             pop_count
);

   localparam logic [SRC_W-1:0] c_last_idx = SRC_W'(NUM_IN - 1);
   localparam logic [SRC_W:0]   c_num_in   = (SRC_W + 1)'(NUM_IN);

   logic [SRC_W-1:0] r_rr_ptr;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [SRC_W-1:0] r_out_src;
   logic [15:0]      r_pop_count;

   logic             w_accept;
   logic             w_any;
   logic             w_pop;
   logic [SRC_W-1:0] w_grant;
   logic [SRC_W-1:0] w_next_ptr;
   logic [WIDTH-1:0] w_head;
   logic [SRC_W:0]   w_cand;

   assign w_accept = !r_out_valid || out_ready;
   assign w_pop    = w_accept && w_any && !rst;

   // Scan from the highest offset down so the nearest non-empty FIFO at or
   // after rr_ptr is the last one written, i.e. the winner.
   always_comb begin
      w_any   = 1'b0;
      w_grant = '0;
      w_cand  = '0;
      for (int k = NUM_IN - 1; k >= 0; k--) begin
         w_cand = {1'b0, r_rr_ptr} + (SRC_W + 1)'(k);
         if (w_cand >= c_num_in) begin
            w_cand = w_cand - c_num_in;
         end
         if (!in_empty[w_cand[SRC_W-1:0]]) begin
            w_any   = 1'b1;
            w_grant = w_cand[SRC_W-1:0];
         end
      end
   end

   always_comb begin
      w_head   = '0;
      in_rd_en = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (w_grant == SRC_W'(i)) begin
            w_head      = in_dout[i*WIDTH +: WIDTH];
            in_rd_en[i] = w_pop;
         end
      end
   end

   assign w_next_ptr = (w_grant == c_last_idx) ? '0 : w_grant + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_src   <= '0;
         r_rr_ptr    <= '0;
         r_pop_count <= '0;
      end else if (w_pop) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_head;
         r_out_src   <= w_grant;
         r_rr_ptr    <= w_next_ptr;
         r_pop_count <= r_pop_count + 16'd1;
      end else if (w_accept) begin
         // Nothing to refill with: the held event left (or none was held).
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_src   = r_out_src;
   assign pop_count = r_pop_count;

endmodule
`default_nettype wire

// File: tb/tb_event_rr_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_event_rr_dispatch
// Purpose  : Directed bench with FWFT FIFO models and an output scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_event_rr_dispatch;

   localparam int WIDTH  = 32;
   localparam int NUM_IN = 4;
   localparam int SRC_W  = 2;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SRC_W-1:0] src;
   } exp_t;

   logic                    clk       = 1'b0;
   logic                    rst       = 1'b1;
   logic                    out_ready = 1'b0;
   logic [NUM_IN-1:0]       in_empty;
   logic [NUM_IN*WIDTH-1:0] in_dout;
   logic [NUM_IN-1:0]       in_rd_en;
   logic                    out_valid;
   logic [WIDTH-1:0]        out_data;
   logic [SRC_W-1:0]        out_src;
   logic [15:0]             pop_count;

   logic [WIDTH-1:0]  fifo_mem [NUM_IN][16];
   logic [3:0]        fifo_rp  [NUM_IN] = '{default: '0};
   logic [3:0]        fifo_wp  [NUM_IN] = '{default: '0};
   logic [4:0]        fifo_cnt [NUM_IN] = '{default: '0};
   logic [NUM_IN-1:0] push_req = '0;
   logic [WIDTH-1:0]  push_val [NUM_IN] = '{default: '0};

   exp_t              exp_q[$];
   int                n_checks = 0;
   int                n_errors = 0;
   logic [NUM_IN-1:0] rd_seen  = '0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      for (int i = 0; i < NUM_IN; i++) begin
         if (push_req[i]) begin
            fifo_mem[i][fifo_wp[i]] <= push_val[i];
            fifo_wp[i]              <= fifo_wp[i] + 4'd1;
         end
         if (in_rd_en[i]) begin
            fifo_rp[i] <= fifo_rp[i] + 4'd1;
         end
         fifo_cnt[i] <= fifo_cnt[i] + {4'd0, push_req[i]} - {4'd0, in_rd_en[i]};
      end
   end

   always_comb begin
      in_empty = '0;
      in_dout  = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         in_empty[i]               = (fifo_cnt[i] == 5'd0);
         in_dout[i*WIDTH +: WIDTH] = fifo_mem[i][fifo_rp[i]];
      end
   end

   event_rr_dispatch #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN),
      .SRC_W  (SRC_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_empty  (in_empty),
      .in_dout   (in_dout),
      .in_rd_en  (in_rd_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src),
      .pop_count (pop_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic expect_ev(input logic [WIDTH-1:0] d, input logic [SRC_W-1:0] s);
      exp_t e;
      e.data = d;
      e.src  = s;
      exp_q.push_back(e);
   endtask

   // Pushes one word into each FIFO selected by mask at the next rising edge.
   task automatic push4(input logic [NUM_IN-1:0] mask, input logic [WIDTH-1:0] d0,
                        input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2,
                        input logic [WIDTH-1:0] d3);
      push_req    = mask;
      push_val[0] = d0;
      push_val[1] = d1;
      push_val[2] = d2;
      push_val[3] = d3;
      @(negedge clk);
      push_req = '0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_done", 32'(exp_q.size()) + 32'(out_valid), 32'd0);
   endtask

   task automatic stream(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check("stream_valid", 32'(out_valid), 32'd1);
      end
   endtask

   // Monitor: rd_en legality, stall stability and scoreboard on every transfer.
   initial begin
      exp_t             e;
      logic             prev_stall;
      logic [WIDTH-1:0] prev_data;
      logic [SRC_W-1:0] prev_src;
      int               viol;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_src   = '0;
      forever begin
         @(negedge clk);
         #2;
         viol = 0;
         if (rst && in_rd_en != '0) viol++;
         if (!$onehot0(in_rd_en)) viol++;
         if ((in_rd_en & in_empty) != '0) viol++;
         check("rd_en_violations", 32'(viol), 32'd0);
         if (!rst) rd_seen = rd_seen | in_rd_en;
         if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", out_data, prev_data);
            check("stall_src", 32'(out_src), 32'(prev_src));
         end
         prev_stall = out_valid && !out_ready && !rst;
         prev_data  = out_data;
         prev_src   = out_src;
         if (out_valid && out_ready && !rst) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL sb_unexpected: got data 0x%0h src %0d expected no event",
                        out_data, out_src);
            end else begin
               e = exp_q.pop_front();
               check("sb_data", out_data, e.data);
               check("sb_src", 32'(out_src), 32'(e.src));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);

      // Reset held while FIFO 0 is non-empty
      push4(4'b0001, 32'h12, '0, '0, '0);
      #1;
      check("rst_rd_en", 32'(in_rd_en), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", out_data, 32'd0);
      check("rst_src", 32'(out_src), 32'd0);
      check("rst_pop_count", 32'(pop_count), 32'd0);
      @(negedge clk);
      check("rst_rd_en_2", 32'(in_rd_en), 32'd0);
      check("rst_valid_2", 32'(out_valid), 32'd0);
      rst       = 1'b0;
      out_ready = 1'b1;
      expect_ev(32'h12, 2'd0);
      #1;
      check("first_rd_en", 32'(in_rd_en), 32'b0001);
      @(negedge clk);
      check("first_valid", 32'(out_valid), 32'd1);
      check("first_data", out_data, 32'h12);
      check("first_src", 32'(out_src), 32'd0);
      check("first_pop_count", 32'(pop_count), 32'd1);
      wait_drain(20);
      check("first_fifo_empty", 32'(in_empty[0]), 32'd1);

      // Fairness with all four FIFOs loaded
      rst = 1'b1;
      for (int r = 0; r < 4; r++) begin
         expect_ev(32'hA0, 2'd0);
         expect_ev(32'hA1, 2'd1);
         expect_ev(32'hA2, 2'd2);
         expect_ev(32'hA3, 2'd3);
         push4(4'b1111, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
      end
      rst = 1'b0;
      stream(16);
      check("fair_pop_count", 32'(pop_count), 32'd16);
      check("fair_all_empty", 32'(in_empty), 32'hF);
      @(negedge clk);
      check("fair_valid_drop", 32'(out_valid), 32'd0);
      wait_drain(20);

      // Backpressure on FIFO 2
      rst       = 1'b1;
      out_ready = 1'b0;
      push4(4'b0100, '0, '0, 32'h25, '0);
      push4(4'b0100, '0, '0, 32'h37, '0);
      push4(4'b0100, '0, '0, 32'h11, '0);
      expect_ev(32'h25, 2'd2);
      expect_ev(32'h37, 2'd2);
      expect_ev(32'h11, 2'd2);
      rst     = 1'b0;
      rd_seen = '0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_data", out_data, 32'h25);
         check("bp_rd_en", 32'(in_rd_en), 32'd0);
         check("bp_pop_count", 32'(pop_count), 32'd1);
      end
      check("bp_fifo_cnt", 32'(fifo_cnt[2]), 32'd2);
      out_ready = 1'b1;
      wait_drain(20);
      check("bp_pop_total", 32'(pop_count), 32'd3);
      check("bp_rd_seen", 32'(rd_seen), 32'b0100);

      // Pointer skip: move rr_ptr to 2, then only FIFOs 1 and 3 hold data
      rst = 1'b1;
      push4(4'b0010, '0, 32'h0B, '0, '0);
      expect_ev(32'h0B, 2'd1);
      rst = 1'b0;
      wait_drain(20);
      rd_seen = '0;
      expect_ev(32'h61, 2'd3);
      expect_ev(32'h41, 2'd1);
      expect_ev(32'h62, 2'd3);
      expect_ev(32'h42, 2'd1);
      push4(4'b1010, '0, 32'h41, '0, 32'h61);
      push4(4'b1010, '0, 32'h42, '0, 32'h62);
      wait_drain(30);
      check("skip_rd_seen", 32'(rd_seen), 32'b1010);
      check("skip_pop_count", 32'(pop_count), 32'd5);

      // Full FIFO 0 drain
      rst = 1'b1;
      for (int k = 0; k < 16; k++) begin
         expect_ev(WIDTH'(32'h11 + k % 4), 2'd0);
         push4(4'b0001, WIDTH'(32'h11 + k % 4), '0, '0, '0);
      end
      check("full_count", 32'(fifo_cnt[0]), 32'd16);
      rst = 1'b0;
      stream(16);
      check("full_pop_count", 32'(pop_count), 32'd16);
      @(negedge clk);
      check("full_valid_drop", 32'(out_valid), 32'd0);
      check("full_fifo_empty", 32'(in_empty[0]), 32'd1);
      wait_drain(20);

      // Reset while an event is held
      rst       = 1'b1;
      out_ready = 1'b0;
      push4(4'b0011, 32'h44, 32'h66, '0, '0);
      push4(4'b0001, 32'h55, '0, '0, '0);
      rst = 1'b0;
      @(negedge clk);
      check("mid_valid", 32'(out_valid), 32'd1);
      check("mid_data", out_data, 32'h44);
      check("mid_pop_count", 32'(pop_count), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_data", out_data, 32'd0);
      check("mid_rst_pop_count", 32'(pop_count), 32'd0);
      check("mid_fifo0_cnt", 32'(fifo_cnt[0]), 32'd1);
      check("mid_fifo1_cnt", 32'(fifo_cnt[1]), 32'd1);
      rst       = 1'b0;
      out_ready = 1'b1;
      expect_ev(32'h55, 2'd0);
      expect_ev(32'h66, 2'd1);
      wait_drain(20);
      check("mid_pop_total", 32'(pop_count), 32'd2);

      repeat (2) @(negedge clk);
      check("sb_leftover", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
